// File: rtl/mem_dump_tx_pkg.sv
// rtl/mem_dump_tx_pkg.sv - shared state encodings and UART frame constants for the memory dump transmitter
package mem_dump_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SEND,
        ST_FIN
    } dump_state_e;

    typedef enum logic [1:0] {
        BIT_IDLE,
        BIT_START,
        BIT_DATA,
        BIT_STOP
    } bit_state_e;

    localparam logic START_BIT      = 1'b0;
    localparam logic STOP_BIT       = 1'b1;
    localparam int   BITS_PER_BYTE  = 8;
    localparam int   BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serializer with START/DATA/STOP bit timing
module uart_tx_byte
    import mem_dump_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load_i,
    input  logic [7:0] byte_i,
    output logic       tx_o,
    output logic       ready_o
);

    localparam int             TW       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0]  TMAX     = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     LAST_BIT = 3'(BITS_PER_BYTE - 1);

    bit_state_e     state_q;
    logic [TW-1:0]  timer_q;
    logic [2:0]     bit_q;
    logic [7:0]     shreg_q;
    logic           tx_q;
    logic           timer_done;

    assign timer_done = (timer_q == '0);
    // Ready in the last stop-bit cycle so the next start bit follows with no gap.
    assign ready_o    = (state_q == BIT_IDLE) || ((state_q == BIT_STOP) && timer_done);
    assign tx_o       = tx_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= BIT_IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= STOP_BIT;
        end else if (load_i && ready_o) begin
            state_q <= BIT_START;
            timer_q <= TMAX;
            bit_q   <= '0;
            shreg_q <= byte_i;
            tx_q    <= START_BIT;
        end else begin
            case (state_q)
                BIT_START: begin
                    if (timer_done) begin
                        state_q <= BIT_DATA;
                        timer_q <= TMAX;
                        tx_q    <= shreg_q[0];
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                BIT_DATA: begin
                    if (timer_done) begin
                        timer_q <= TMAX;
                        if (bit_q == LAST_BIT) begin
                            state_q <= BIT_STOP;
                            tx_q    <= STOP_BIT;
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            shreg_q <= shreg_q >> 1;
                            tx_q    <= shreg_q[1];
                        end
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                BIT_STOP: begin
                    if (timer_done) begin
                        state_q <= BIT_IDLE;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                default: begin
                    tx_q <= STOP_BIT;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_dump_tx.sv
// rtl/mem_dump_tx.sv - reads a word range from memory and sends it as UART 8N1, LSB byte first
module mem_dump_tx
    import mem_dump_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_count,
    output logic [31:0]      mem_Address,
    output logic             mem_CS,
    output logic             mem_OE,
    input  logic [31:0]      mem_DataOut,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    dump_state_e      state_q;
    logic [CNT_W-1:0] remaining_q;
    logic [31:0]      word_q;
    logic [31:0]      mem_addr_q;
    logic [1:0]       byte_idx_q;
    logic             busy_q;
    logic             done_q;
    logic             mem_oe_q;
    logic             mem_cs_q;
    logic             uart_load;
    logic             uart_ready;
    logic [7:0]       uart_byte;

    assign mem_Address = mem_addr_q;
    assign mem_CS      = mem_cs_q;
    assign mem_OE      = mem_oe_q;
    assign busy        = busy_q;
    assign done        = done_q;

    // Byte 0 goes straight from the memory bus so its start bit begins as LOAD ends.
    always_comb begin
        uart_load = 1'b0;
        uart_byte = word_q[7:0];
        if (state_q == ST_LOAD) begin
            uart_load = 1'b1;
            uart_byte = mem_DataOut[7:0];
        end else if ((state_q == ST_SEND) && uart_ready && (byte_idx_q != LAST_BYTE)) begin
            uart_load = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            word_q      <= '0;
            mem_addr_q  <= '0;
            byte_idx_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_oe_q    <= 1'b0;
            mem_cs_q    <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        busy_q      <= 1'b1;
                        remaining_q <= word_count;
                        if (word_count == '0) begin
                            state_q <= ST_FIN;
                        end else begin
                            state_q    <= ST_FETCH;
                            mem_addr_q <= base_addr;
                            mem_oe_q   <= 1'b1;
                            mem_cs_q   <= 1'b0;
                        end
                    end
                end
                ST_FETCH: begin
                    state_q  <= ST_LOAD;
                    mem_oe_q <= 1'b0;
                    mem_cs_q <= 1'b1;
                end
                ST_LOAD: begin
                    state_q    <= ST_SEND;
                    word_q     <= mem_DataOut >> 8;
                    byte_idx_q <= '0;
                end
                ST_SEND: begin
                    if (uart_ready) begin
                        if (byte_idx_q != LAST_BYTE) begin
                            byte_idx_q <= byte_idx_q + 1'b1;
                            word_q     <= word_q >> 8;
                        end else if (remaining_q > CNT_W'(1)) begin
                            state_q     <= ST_FETCH;
                            remaining_q <= remaining_q - 1'b1;
                            mem_addr_q  <= mem_addr_q + 32'd1;
                            mem_oe_q    <= 1'b1;
                            mem_cs_q    <= 1'b0;
                        end else begin
                            state_q <= ST_FIN;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clock  (clock),
        .reset  (reset),
        .load_i (uart_load),
        .byte_i (uart_byte),
        .tx_o   (tx),
        .ready_o(uart_ready)
    );

endmodule

// File: tb/tb_mem_dump_tx.sv
// tb/tb_mem_dump_tx.sv - directed self-checking bench for mem_dump_tx
module tb_mem_dump_tx;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] word_count = '0;
    logic [31:0] mem_Address;
    logic        mem_CS;
    logic        mem_OE;
    logic [31:0] mem_DataOut = '0;
    logic        tx;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int oe_cnt, busy_cnt, done_cnt, tx_low_cnt, ferr;
    logic [31:0] addr_q[$];
    logic [7:0]  rx_q[$];
    int          ts_q[$];
    logic [7:0]  rx_b;
    int          rx_t;

    mem_dump_tx #(.CLKS_PER_BIT(4), .CNT_W(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .mem_Address(mem_Address),
        .mem_CS     (mem_CS),
        .mem_OE     (mem_OE),
        .mem_DataOut(mem_DataOut),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h0000_0010: return 32'h1122_3344;
            32'h0000_0020: return 32'hA5A5_A5A5;
            32'h0000_0021: return 32'h0000_0000;
            32'h0000_0022: return 32'hFFFF_FFFF;
            32'hFFFF_FFFF: return 32'hDEAD_BEEF;
            32'h0000_0000: return 32'h0102_0304;
            default:       return 32'hBAD0_BAD0;
        endcase
    endfunction

    always @(posedge clock) begin
        if (mem_OE && !mem_CS) mem_DataOut <= mem_rd(mem_Address);
    end

    always @(negedge clock) begin
        if (mem_OE) begin
            oe_cnt++;
            addr_q.push_back(mem_Address);
        end
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (tx === 1'b0) tx_low_cnt++;
    end

    always begin : rx_mon
        @(negedge clock);
        if (tx === 1'b0) begin
            rx_t = cyc;
            repeat (2) @(negedge clock);
            if (tx !== 1'b0) ferr++;
            for (int k = 0; k < 8; k++) begin
                repeat (4) @(negedge clock);
                rx_b[k] = tx;
            end
            repeat (4) @(negedge clock);
            if (tx !== 1'b1) ferr++;
            rx_q.push_back(rx_b);
            ts_q.push_back(rx_t);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        oe_cnt = 0; busy_cnt = 0; done_cnt = 0; tx_low_cnt = 0; ferr = 0;
        addr_q.delete(); rx_q.delete(); ts_q.delete();
    endtask

    task automatic pulse_start(input logic [31:0] b, input logic [15:0] c);
        @(negedge clock);
        start = 1'b1; base_addr = b; word_count = c;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic run(input logic [31:0] b, input logic [15:0] c);
        int i;
        clear_stats();
        pulse_start(b, c);
        for (i = 0; i < 3000 && done_cnt == 0; i++) @(negedge clock);
        check("done_timeout", 64'(i < 3000), 64'd1);
        repeat (5) @(negedge clock);
    endtask

    task automatic check_bytes(input string tag, input logic [31:0] w);
        logic [31:0] tmp;
        tmp = w;
        for (int k = 0; k < 4; k++) begin
            check(tag, (rx_q.size() > 0) ? 64'(rx_q.pop_front()) : 64'hDEAD, 64'(tmp[7:0]));
            tmp = tmp >> 8;
        end
    endtask

    initial begin
        int i;
        repeat (3) @(negedge clock);
        check("rst_tx", 64'(tx), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_oe", 64'(mem_OE), 64'd0);
        check("rst_cs", 64'(mem_CS), 64'd1);
        check("rst_addr", 64'(mem_Address), 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // single word, busy length and bus activity
        run(32'h10, 16'd1);
        check("t1_oe_cnt", 64'(oe_cnt), 64'd1);
        check("t1_addr", 64'(addr_q.size() > 0 ? addr_q[0] : 32'hFFFF_0000), 64'h10);
        check("t1_nbytes", 64'(rx_q.size()), 64'd4);
        check_bytes("t1_byte", 32'h1122_3344);
        check("t1_busy_cycles", 64'(busy_cnt), 64'd163);
        check("t1_done_cnt", 64'(done_cnt), 64'd1);
        check("t1_ferr", 64'(ferr), 64'd0);

        // three words, byte order and inter-word gap
        run(32'h20, 16'd3);
        check("t2_nbytes", 64'(rx_q.size()), 64'd12);
        check("t2_oe_cnt", 64'(oe_cnt), 64'd3);
        for (int k = 0; k < 3; k++)
            check("t2_addr", 64'(addr_q.size() > k ? addr_q[k] : 32'hFFFF_0000), 64'(32'h20 + k));
        for (int k = 1; k < 12; k++)
            check("t2_frame_spacing", 64'(ts_q.size() > k ? ts_q[k] - ts_q[k-1] : 0),
                  (k % 4 == 0) ? 64'd42 : 64'd40);
        check_bytes("t2_w0", 32'hA5A5_A5A5);
        check_bytes("t2_w1", 32'h0000_0000);
        check_bytes("t2_w2", 32'hFFFF_FFFF);
        check("t2_ferr", 64'(ferr), 64'd0);

        // address wraps
        run(32'hFFFF_FFFF, 16'd2);
        check("t3_oe_cnt", 64'(oe_cnt), 64'd2);
        check("t3_addr0", 64'(addr_q.size() > 0 ? addr_q[0] : 32'h1234), 64'hFFFF_FFFF);
        check("t3_addr1", 64'(addr_q.size() > 1 ? addr_q[1] : 32'h1234), 64'h0);
        check("t3_nbytes", 64'(rx_q.size()), 64'd8);
        check_bytes("t3_w0", 32'hDEAD_BEEF);
        check_bytes("t3_w1", 32'h0102_0304);

        // zero count
        clear_stats();
        pulse_start(32'h10, 16'd0);
        check("t4_busy_first", 64'(busy), 64'd1);
        check("t4_done_first", 64'(done), 64'd0);
        @(negedge clock);
        check("t4_done_pulse", 64'(done), 64'd1);
        check("t4_busy_after", 64'(busy), 64'd0);
        repeat (5) @(negedge clock);
        check("t4_oe_cnt", 64'(oe_cnt), 64'd0);
        check("t4_tx_low", 64'(tx_low_cnt), 64'd0);
        check("t4_busy_cycles", 64'(busy_cnt), 64'd1);
        check("t4_done_cnt", 64'(done_cnt), 64'd1);

        // start while busy is ignored
        clear_stats();
        pulse_start(32'h10, 16'd1);
        repeat (50) @(negedge clock);
        pulse_start(32'h99, 16'd5);
        for (i = 0; i < 3000 && done_cnt == 0; i++) @(negedge clock);
        check("t5_done_timeout", 64'(i < 3000), 64'd1);
        repeat (20) @(negedge clock);
        check("t5_oe_cnt", 64'(oe_cnt), 64'd1);
        check("t5_addr", 64'(addr_q.size() > 0 ? addr_q[0] : 32'hFFFF_0000), 64'h10);
        check("t5_nbytes", 64'(rx_q.size()), 64'd4);
        check_bytes("t5_byte", 32'h1122_3344);
        check("t5_done_cnt", 64'(done_cnt), 64'd1);
        check("t5_busy_cycles", 64'(busy_cnt), 64'd163);

        // async reset mid-byte
        clear_stats();
        pulse_start(32'h10, 16'd1);
        for (i = 0; i < 500 && rx_q.size() < 2; i++) @(negedge clock);
        check("t6_wait_bytes", 64'(i < 500), 64'd1);
        repeat (8) @(negedge clock);
        check("t6_pre_tx", 64'(tx), 64'd0);
        check("t6_pre_busy", 64'(busy), 64'd1);
        #1 reset = 1'b0;
        #1;
        check("t6_rst_tx", 64'(tx), 64'd1);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_oe", 64'(mem_OE), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (50) @(negedge clock);
        run(32'h10, 16'd1);
        check("t6_nbytes", 64'(rx_q.size()), 64'd4);
        check_bytes("t6_byte", 32'h1122_3344);
        check("t6_done_cnt", 64'(done_cnt), 64'd1);
        check("t6_ferr", 64'(ferr), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
